// File: rtl/sram_pkg.sv
// Shared types and helpers for the pipelined behavioural SRAM.
package sram_pkg;

  typedef enum logic {INIT, READY} sram_state_t;

  // Widest word the poison helper can produce.
  localparam int unsigned SRAM_POISON_MAX = 1024;

  // Default-width response layout; the top declares the same fields at its own WORD_BITS.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } sram_rsp_t;

  // 32'hBAD0BAD0 repeated from bit 0 upward, bits at or above width cleared.
  function automatic logic [SRAM_POISON_MAX-1:0] poison(input int unsigned width);
    logic [31:0]                pat;
    logic [SRAM_POISON_MAX-1:0] r;
    pat = 32'hBAD0BAD0;
    r   = '0;
    for (int unsigned i = 0; i < SRAM_POISON_MAX; i++) begin
      if (i < width) r[i[9:0]] = pat[i[4:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_delay_line.sv
// Fixed-depth shift register for response records with a synchronous active-low flush.
module sram_delay_line #(
  parameter int unsigned DEPTH_STAGES = 1,
  parameter type         T            = logic
) (
  input  logic CLK,
  input  logic nFLUSH,
  input  T     d,
  output T     q
);

  T stage [DEPTH_STAGES];

  always_ff @(posedge CLK) begin
    if (!nFLUSH) begin
      for (int unsigned i = 0; i < DEPTH_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH_STAGES-1];

endmodule

// File: rtl/sram_pipelined.sv
// Single-port behavioural SRAM with valid/ready requests, byte-masked writes,
// range checking, a post-reset zero sweep and a configurable read latency.
module sram_pipelined
  import sram_pkg::*;
#(
  parameter int unsigned WORD_BITS    = 32,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned BYTE_MASK_EN = 1,
  parameter int unsigned WRITE_ACK    = 0,
  localparam int unsigned AW          = (DEPTH == 1) ? 1 : $clog2(DEPTH),
  localparam int unsigned NB          = WORD_BITS / 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [AW-1:0]        req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  input  logic [NB-1:0]        req_wstrb,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_rdata,
  output logic                 rsp_err
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("sram_pipelined: LATENCY must be 1..4");
  end
  if (WORD_BITS % 8 != 0 || WORD_BITS == 0 || WORD_BITS > SRAM_POISON_MAX) begin : g_bad_width
    $error("sram_pipelined: WORD_BITS must be a non-zero multiple of 8");
  end

  localparam logic [SRAM_POISON_MAX-1:0] POISON_FULL = poison(WORD_BITS);
  localparam logic [WORD_BITS-1:0]       POISON      = POISON_FULL[WORD_BITS-1:0];
  localparam logic [AW-1:0]              LAST        = AW'(DEPTH - 1);

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [WORD_BITS-1:0] data;
  } rsp_t;

  logic [WORD_BITS-1:0] mem [DEPTH];

  sram_state_t          state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 accept;
  logic                 in_range;
  logic                 do_write;
  logic [AW-1:0]        idx;
  logic [NB-1:0]        strb;
  logic [WORD_BITS-1:0] cur;
  logic [WORD_BITS-1:0] merged;
  rsp_t                 rsp_in, rsp_out;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST) state_d = READY;
        else               cnt_d   = cnt_q + AW'(1);
      end
      READY: req_ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset wins over a request presented at the same edge.
  assign accept   = nRST & req_valid & req_ready;
  assign in_range = 32'(req_addr) < DEPTH;
  assign idx      = in_range ? req_addr : '0;
  assign cur      = mem[idx];
  assign strb     = (BYTE_MASK_EN != 0) ? req_wstrb : '1;
  assign do_write = accept & req_wen & in_range;

  always_comb begin
    merged = cur;
    for (int unsigned b = 0; b < NB; b++) begin
      if (strb[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == INIT) mem[cnt_q] <= '0;
    else if (do_write)   mem[idx]   <= merged;
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept & (~req_wen | (WRITE_ACK != 0));
    rsp_in.err   = ~in_range;
    rsp_in.data  = (~in_range | req_wen) ? POISON : cur;
  end

  sram_delay_line #(
    .DEPTH_STAGES(LATENCY),
    .T           (rsp_t)
  ) u_delay (
    .CLK   (CLK),
    .nFLUSH(nRST),
    .d     (rsp_in),
    .q     (rsp_out)
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_err   = rsp_out.valid & rsp_out.err;
  assign rsp_rdata = rsp_out.valid ? rsp_out.data : POISON;

endmodule

// File: tb/tb_sram_pipelined.sv
// Scoreboard bench: two SRAM configurations share one request stream and are
// checked against an array-level model with per-response due cycles.
module tb_sram_pipelined;

  localparam int unsigned DEPTH  = 100;
  localparam int unsigned LAT_A  = 3;
  localparam int unsigned LAT_B  = 1;
  localparam logic [31:0] POISON = 32'hBAD0BAD0;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rdyA, rvA, reA, rdyB, rvB, reB;
  logic [31:0] rdA, rdB;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0, n_bad = 0;
  logic        mon_en = 1'b0;
  exp_t        qA[$], qB[$];
  logic [31:0] memA [DEPTH];
  logic [31:0] memB [DEPTH];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sram_pipelined #(.WORD_BITS(32), .DEPTH(DEPTH), .LATENCY(LAT_A), .BYTE_MASK_EN(1), .WRITE_ACK(0)) dut_a (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(rdyA), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rvA), .rsp_rdata(rdA), .rsp_err(reA));

  sram_pipelined #(.WORD_BITS(32), .DEPTH(DEPTH), .LATENCY(LAT_B), .BYTE_MASK_EN(0), .WRITE_ACK(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(rdyB), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rvB), .rsp_rdata(rdB), .rsp_err(reB));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Monitors: each response must match the queue head, on exactly its due cycle.
  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (mon_en) begin
      n_cmp++;
      if (rvA === 1'b1) begin
        if (qA.size() == 0) begin
          n_bad++;
          $display("FAIL A_unexpected_rsp: cyc=%0d rdata=%h err=%b, no response expected", cyc, rdA, reA);
        end else begin
          e = qA.pop_front();
          if (e.due != cyc || rdA !== e.data || reA !== e.err) begin
            n_bad++;
            $display("FAIL A_rsp: cyc=%0d rdata=%h err=%b, expected cyc=%0d rdata=%h err=%b",
                     cyc, rdA, reA, e.due, e.data, e.err);
          end
        end
      end else begin
        if (rvA !== 1'b0 || rdA !== POISON || reA !== 1'b0) begin
          n_bad++;
          $display("FAIL A_idle: cyc=%0d valid=%b rdata=%h err=%b, expected 0/%h/0", cyc, rvA, rdA, reA, POISON);
        end
        if (qA.size() > 0 && qA[0].due <= cyc) begin
          n_bad++;
          $display("FAIL A_missing_rsp: cyc=%0d no rsp_valid, expected one due at %0d", cyc, qA[0].due);
          void'(qA.pop_front());
        end
      end
    end
  end

  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (mon_en) begin
      n_cmp++;
      if (rvB === 1'b1) begin
        if (qB.size() == 0) begin
          n_bad++;
          $display("FAIL B_unexpected_rsp: cyc=%0d rdata=%h err=%b, no response expected", cyc, rdB, reB);
        end else begin
          e = qB.pop_front();
          if (e.due != cyc || rdB !== e.data || reB !== e.err) begin
            n_bad++;
            $display("FAIL B_rsp: cyc=%0d rdata=%h err=%b, expected cyc=%0d rdata=%h err=%b",
                     cyc, rdB, reB, e.due, e.data, e.err);
          end
        end
      end else begin
        if (rvB !== 1'b0 || rdB !== POISON || reB !== 1'b0) begin
          n_bad++;
          $display("FAIL B_idle: cyc=%0d valid=%b rdata=%h err=%b, expected 0/%h/0", cyc, rvB, rdB, reB, POISON);
        end
        if (qB.size() > 0 && qB[0].due <= cyc) begin
          n_bad++;
          $display("FAIL B_missing_rsp: cyc=%0d no rsp_valid, expected one due at %0d", cyc, qB[0].due);
          void'(qB.pop_front());
        end
      end
    end
  end

  task automatic op(input logic wen, input int unsigned addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    @(negedge CLK);
    n_cmp++;
    if (rdyA !== 1'b1 || rdyB !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_req: A=%b B=%b, expected 1", rdyA, rdyB);
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr[6:0]; req_wdata = data; req_wstrb = strb;
    e.err = (addr >= DEPTH);
    if (wen) begin
      if (addr < DEPTH) begin
        memA[addr] = merge(memA[addr], data, strb);
        memB[addr] = data;
      end
      e.due = cyc + LAT_B; e.data = POISON;
      qB.push_back(e);
    end else begin
      e.due  = cyc + LAT_A;
      e.data = POISON;
      if (addr < DEPTH) e.data = memA[addr];
      qA.push_back(e);
      e.due  = cyc + LAT_B;
      if (addr < DEPTH) e.data = memB[addr];
      qB.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  // Reset for two edges, then measure the INIT window while pushing ignored writes at it.
  task automatic do_reset();
    exp_t keep[$];
    int   zA, zB, g;
    @(negedge CLK);
    req_valid = 1'b0;
    nRST = 1'b0;
    keep = {};
    foreach (qA[i]) if (qA[i].due <= cyc) keep.push_back(qA[i]);
    qA = keep;
    keep = {};
    foreach (qB[i]) if (qB[i].due <= cyc) keep.push_back(qB[i]);
    qB = keep;
    for (int i = 0; i < DEPTH; i++) begin memA[i] = '0; memB[i] = '0; end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 7'd3; req_wdata = '1; req_wstrb = '1;
    zA = 0; zB = 0; g = 0;
    while ((rdyA !== 1'b1 || rdyB !== 1'b1) && g < 1000) begin
      if (rdyA !== 1'b1) zA++;
      if (rdyB !== 1'b1) zB++;
      g++;
      @(negedge CLK);
    end
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    n_cmp++;
    if (zA != DEPTH) begin n_bad++; $display("FAIL A_init_len: ready low %0d cycles, expected %0d", zA, DEPTH); end
    n_cmp++;
    if (zB != DEPTH) begin n_bad++; $display("FAIL B_init_len: ready low %0d cycles, expected %0d", zB, DEPTH); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    mon_en = 1'b1;
    do_reset();

    // Sweep leaves zeros; the write pushed during INIT must not land.
    op(0, 0, '0, '0); op(0, 64, '0, '0); op(0, 99, '0, '0); op(0, 3, '0, '0);
    idle();

    op(1, 5, 32'hDEADBEEF, 4'hF); op(0, 5, '0, '0);
    idle(); repeat (4) idle();

    op(1, 9, 32'h11223344, 4'hF); op(1, 9, 32'hAABBCCDD, 4'b0101); op(0, 9, '0, '0);
    idle();

    for (int i = 0; i < 8; i++) op(1, i, 100 + i, 4'hF);
    for (int i = 0; i < 8; i++) op(0, i, '0, '0);
    idle();

    op(1, 99, 32'h00C0FFEE, 4'hF);
    op(1, 100, 32'h55, 4'hF); op(0, 100, '0, '0); op(0, 99, '0, '0); op(0, 127, '0, '0);
    idle();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 2) idle();
      else op(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom, 4'($urandom_range(0, 15)));
    end
    idle(); repeat (6) idle();

    // Two reads in flight when reset hits; the deeper pipeline must drop them.
    op(1, 20, 32'h12345678, 4'hF);
    op(0, 20, '0, '0); op(0, 5, '0, '0);
    do_reset();
    op(0, 20, '0, '0); op(0, 5, '0, '0);
    idle(); repeat (6) idle();

    n_cmp++;
    if (qA.size() != 0 || qB.size() != 0) begin
      n_bad++;
      $display("FAIL drain: outstanding A=%0d B=%0d, expected 0/0", qA.size(), qB.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
